// File: rtl/ice_stream_rx.sv
// ICEStream pin receiver: registers the enable/data pins, deserializes MSB-first words
// and buffers them in a power-of-two FIFO drained through a valid/ready port.
module ice_stream_rx #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pin_en,
  input  logic                     pin_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              word_cnt,
  output logic                     err_ovf,
  output logic                     err_frame
);

  localparam int unsigned CntW  = $clog2(WORD_W);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e stateQ, stateD;

  logic              enQ, dQ;
  logic [WORD_W-2:0] shiftQ, shiftD;
  logic [WORD_W-1:0] shiftNext;
  logic [CntW-1:0]   bitCntQ, bitCntD;
  logic              wordDone, frameErr;

  logic              pushQ;
  logic [WORD_W-1:0] pushDataQ;
  logic [PtrW-1:0]   wrPtrQ, rdPtrQ, fill;
  logic [15:0]       wordCntQ;
  logic              errOvfQ, errFrameQ;
  logic              empty, full, pop, accept;

  logic [WORD_W-1:0] mem [DEPTH];

  // Pin input stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enQ <= 1'b0;
      dQ  <= 1'b0;
    end else begin
      enQ <= pin_en;
      dQ  <= pin_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (enQ) stateD = StRecv;
      StRecv:  if (!enQ) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // FSM outputs: shift/bit-count updates, word completion and framing error
  assign shiftNext = {shiftQ, dQ};

  always_comb begin
    shiftD   = shiftQ;
    bitCntD  = bitCntQ;
    wordDone = 1'b0;
    frameErr = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (enQ) begin
          shiftD  = shiftNext[WORD_W-2:0];
          bitCntD = CntW'(1);
        end
      end
      StRecv: begin
        if (enQ) begin
          shiftD = shiftNext[WORD_W-2:0];
          if (bitCntQ == LastBit) begin
            wordDone = 1'b1;
            bitCntD  = '0;
          end else begin
            bitCntD = bitCntQ + CntW'(1);
          end
        end else begin
          frameErr = (bitCntQ != '0);
          bitCntD  = '0;
        end
      end
      default: ;
    endcase
  end

  // Completed words spend one cycle in a holding register before the FIFO write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftQ    <= '0;
      bitCntQ   <= '0;
      pushQ     <= 1'b0;
      pushDataQ <= '0;
      errFrameQ <= 1'b0;
    end else begin
      shiftQ  <= shiftD;
      bitCntQ <= bitCntD;
      pushQ   <= wordDone;
      if (wordDone) pushDataQ <= shiftNext;
      if (frameErr) errFrameQ <= 1'b1;
    end
  end

  assign fill   = wrPtrQ - rdPtrQ;
  assign empty  = (fill == '0);
  assign full   = (fill == PtrW'(DEPTH));
  assign pop    = !empty && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the word
  assign accept = pushQ && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ   <= '0;
      rdPtrQ   <= '0;
      wordCntQ <= '0;
      errOvfQ  <= 1'b0;
    end else begin
      if (pop) rdPtrQ <= rdPtrQ + PtrW'(1);
      if (accept) begin
        wrPtrQ   <= wrPtrQ + PtrW'(1);
        wordCntQ <= wordCntQ + 16'd1;
      end else if (pushQ) begin
        errOvfQ <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wrPtrQ[AddrW-1:0]] <= pushDataQ;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rdPtrQ[AddrW-1:0]];
  assign level     = fill;
  assign word_cnt  = wordCntQ;
  assign err_ovf   = errOvfQ;
  assign err_frame = errFrameQ;

endmodule
